// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, PC step and
// redirect alignment.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

  // Low address bits cleared on redirect targets (word alignment).
  localparam int unsigned ALIGN_LSBS = 3;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts unacknowledged request cycles; o_reached flags the cycle whose
// increment brings the count to MAX_WAIT.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_reached
);

  logic [7:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_reached = i_enable && (r_count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch control: owns the PC, runs the req/ack exchange with
// instruction memory, buffers one word for decode and applies redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           MAX_WAIT     = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  output logic                  fetch_timeout
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(ALIGN_LSBS);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  r_req;
  logic                  w_req_nxt;
  logic                  w_ack;
  logic                  w_redirect;
  logic                  w_load;
  logic                  w_tmr_clear;
  logic                  w_tmr_en;
  logic                  w_tmr_reached;
  logic [DATA_WIDTH-1:0] r_inst_data;
  logic [ADDR_WIDTH-1:0] r_inst_pc;

  assign w_target   = redirect_target & ALIGN_MASK;
  assign w_redirect = redirect_valid && (r_state != S_ERR);
  // r_req is only ever high in S_REQ, so this also drops acks in other states.
  assign w_ack      = imem_ack && r_req;

  // Kept outside the FSM block so the timer's reached flag has no comb loop.
  assign w_tmr_clear = w_redirect || w_ack;
  assign w_tmr_en    = (r_state == S_REQ) && r_req && !w_ack && !w_redirect;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_reached (w_tmr_reached)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_REQ: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (w_ack) begin
          w_load      = 1'b1;
          w_pc_nxt    = r_pc + STEP;
          w_state_nxt = S_OUT;
        end else if (w_tmr_reached) begin
          w_state_nxt = S_ERR;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_inst_data <= '0;
      r_inst_pc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_req_nxt ? w_pc_nxt : '0;
      if (w_load) begin
        r_inst_data <= imem_rdata;
        r_inst_pc   <= r_pc;
      end
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_addr;
  assign inst_valid    = (r_state == S_OUT);
  assign inst_data     = r_inst_data;
  assign inst_pc       = r_inst_pc;
  assign fetch_timeout = (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .MAX_WAIT     (15)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .fetch_timeout   (fetch_timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(imem_req),      32'd0);
    chk({tag, "_addr"},  imem_addr,          32'd0);
    chk({tag, "_valid"}, 32'(inst_valid),    32'd0);
    chk({tag, "_data"},  inst_data,          32'd0);
    chk({tag, "_pc"},    inst_pc,            32'd0);
    chk({tag, "_tmo"},   32'(fetch_timeout), 32'd0);
  endtask

  // Expects a live request at addr, answers it in the same cycle, then
  // expects the word in the output buffer.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data);
    chk("fw_req",  32'(imem_req), 32'd1);
    chk("fw_addr", imem_addr,     addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("fw_valid",   32'(inst_valid), 32'd1);
    chk("fw_data",    inst_data,       data);
    chk("fw_pc",      inst_pc,         addr);
    chk("fw_req_out", 32'(imem_req),   32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b1;

    #1;
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    chk("bubble_req", 32'(imem_req), 32'd0);
    tick();

    // Straight-line fetch with immediate acks and decode always ready
    fetch_word(32'h0000_0000, 32'hA000_0000);
    tick();
    chk("hs0_valid", 32'(inst_valid), 32'd0);
    fetch_word(32'h0000_0004, 32'hA000_0004);
    tick();
    fetch_word(32'h0000_0008, 32'hA000_0008);

    // Decode stall
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_data",  inst_data,       32'hA000_0008);
      chk("stall_pc",    inst_pc,         32'h0000_0008);
      chk("stall_req",   32'(imem_req),   32'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("post_stall_req",  32'(imem_req), 32'd1);
    chk("post_stall_addr", imem_addr,     32'h0000_000C);
    fetch_word(32'h0000_000C, 32'hA000_000C);

    // Redirect in S_OUT with a same-cycle handshake: buffer is flushed
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("rdo_valid", 32'(inst_valid), 32'd0);
    chk("rdo_req",   32'(imem_req),   32'd0);
    tick();
    chk("rdo_req2",  32'(imem_req),   32'd1);
    chk("rdo_addr",  imem_addr,       32'h0000_0100);

    // Redirect concurrent with ack: response discarded
    imem_ack        = 1'b1;
    imem_rdata      = 32'hDEAD_BEEF;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    chk("rda_valid", 32'(inst_valid), 32'd0);
    chk("rda_req",   32'(imem_req),   32'd0);
    tick();
    chk("rda_valid2", 32'(inst_valid), 32'd0);
    fetch_word(32'h0000_0200, 32'hB000_0200);

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_flush", 32'(inst_valid), 32'd0);
    tick();
    fetch_word(32'hFFFF_FFFC, 32'hC000_FFFC);
    tick();
    chk("wrap_req",  32'(imem_req), 32'd1);
    chk("wrap_addr", imem_addr,     32'h0000_0000);

    // Asynchronous reset mid-request, then a late ack during idle
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0001;
    reset      = 1'b0;
    chk("late_ack_req",   32'(imem_req),   32'd0);
    chk("late_ack_valid", 32'(inst_valid), 32'd0);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("restart_req",   32'(imem_req),   32'd1);
    chk("restart_addr",  imem_addr,       32'h0000_0000);
    chk("restart_valid", 32'(inst_valid), 32'd0);

    // Withheld ack: 15 unanswered cycles raise the sticky timeout
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("wait_tmo", 32'(fetch_timeout), 32'd0);
      chk("wait_req", 32'(imem_req),      32'd1);
    end
    tick();
    chk("tmo_rise",  32'(fetch_timeout), 32'd1);
    chk("tmo_req",   32'(imem_req),      32'd0);
    chk("tmo_valid", 32'(inst_valid),    32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("tmo_sticky_rd", 32'(fetch_timeout), 32'd1);
    chk("tmo_rd_req",    32'(imem_req),      32'd0);
    tick();
    chk("tmo_sticky2",   32'(fetch_timeout), 32'd1);
    chk("tmo_req2",      32'(imem_req),      32'd0);

    reset = 1'b1;
    #1;
    chk("tmo_clear", 32'(fetch_timeout), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("final_req",  32'(imem_req), 32'd1);
    chk("final_addr", imem_addr,     32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
